// File: rtl/nmr_bstrm_rle_expander.sv
// Run-length expander: turns {count, pattern} FIFO entries into count+1 consecutive pattern words for the bitstream player.
// Optional macro RLE_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow cycle counter output.
module nmr_bstrm_rle_expander #(
    parameter int BUS_WIDTH = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [BUS_WIDTH+CNT_WIDTH-1:0] in_data,
    input  logic                           in_empty,
    output logic                           in_rdreq,
    output logic [BUS_WIDTH-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_rdreq,
    input  logic                           flush,
    output logic                           underflow
`ifdef RLE_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                    underflow_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state, state_nxt;
    logic [BUS_WIDTH-1:0] pat_q;
    logic [CNT_WIDTH-1:0] rem_q;
    logic                 underflow_q;

    logic                 load;
    logic                 dec;
    logic                 stall_enter;
    logic                 stall_strobe;
    logic                 last_word;

    assign last_word = (rem_q == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (load)        state_nxt = RUN;
                RUN:     if (stall_enter) state_nxt = STALL;
                STALL:   if (load)        state_nxt = RUN;
                default:                  state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        load         = 1'b0;
        dec          = 1'b0;
        stall_enter  = 1'b0;
        stall_strobe = 1'b0;
        if (!flush) begin
            case (state)
                IDLE: load = !in_empty;
                RUN: begin
                    if (out_rdreq) begin
                        if (!last_word)     dec         = 1'b1;
                        else if (!in_empty) load        = 1'b1;
                        else                stall_enter = 1'b1;
                    end
                end
                STALL: begin
                    load         = !in_empty;
                    stall_strobe = out_rdreq;
                end
                default: ;
            endcase
        end
        // The FIFO must never be popped while reset is held, even though IDLE would otherwise prime.
        in_rdreq  = load & ~RST;
        out_valid = (state != IDLE);
        out_data  = out_valid ? pat_q : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pat_q       <= '0;
            rem_q       <= '0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            pat_q       <= '0;
            rem_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (load) begin
                pat_q <= in_data[BUS_WIDTH-1:0];
                rem_q <= in_data[BUS_WIDTH +: CNT_WIDTH];
            end else if (dec) begin
                rem_q <= rem_q - CNT_ONE;
            end
            if (stall_enter || stall_strobe) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign underflow = underflow_q;

`ifdef RLE_UNDERFLOW_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ucnt_q <= '0;
        end else if (flush) begin
            ucnt_q <= '0;
        end else if ((stall_enter || stall_strobe) && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underflow_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_nmr_bstrm_rle_expander.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based word-stream model of the expander.
module tb_nmr_bstrm_rle_expander;

    localparam int BW = 32;
    localparam int CW = 16;

    logic              CLK;
    logic              RST;
    logic [BW+CW-1:0]  in_data;
    logic              in_empty;
    logic              in_rdreq;
    logic [BW-1:0]     out_data;
    logic              out_valid;
    logic              out_rdreq;
    logic              flush;
    logic              underflow;
`ifdef RLE_UNDERFLOW_CNT_EN
    logic [15:0]       underflow_cnt;
`endif

    nmr_bstrm_rle_expander #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .in_empty  (in_empty),
        .in_rdreq  (in_rdreq),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_rdreq (out_rdreq),
        .flush     (flush),
        .underflow (underflow)
`ifdef RLE_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Command FIFO contents and the reference model of the presented word stream.
    logic [BW+CW-1:0] fifo[$];
    logic [BW-1:0]    m_words[$];
    logic [BW-1:0]    m_last;
    bit               m_idle;
    bit               m_uf;
    int               m_ucnt;

    int               pops_seen;
    logic [BW-1:0]    watch_pat;
    int               watch_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int cnt, input logic [BW-1:0] pat);
        logic [CW-1:0] c;
        c = CW'(cnt);
        fifo.push_back({c, pat});
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_words.delete();
        m_last = '0;
        m_uf   = 1'b0;
        m_ucnt = 0;
    endtask

    task automatic model_load();
        logic [BW+CW-1:0] e;
        e = fifo.pop_front();
        for (int i = 0; i <= int'(e[BW +: CW]); i++) m_words.push_back(e[BW-1:0]);
    endtask

    task automatic model_underflow();
        m_uf = 1'b1;
        if (m_ucnt < 65535) m_ucnt++;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cycle(input logic rd, input logic fl);
        logic          pop;
        logic          e_valid;
        logic [BW-1:0] e_data;
        out_rdreq = rd;
        flush     = fl;
        in_empty  = (fifo.size() == 0);
        in_data   = (fifo.size() != 0) ? fifo[0] : '0;
        #1;
        e_valid = !m_idle;
        e_data  = m_idle ? '0 : ((m_words.size() != 0) ? m_words[0] : m_last);
        pop = !fl && (fifo.size() != 0) &&
              (m_idle || (m_words.size() == 0) || (rd && (m_words.size() == 1)));
        check("out_valid", 64'(out_valid), 64'(e_valid));
        check("out_data", 64'(out_data), 64'(e_data));
        check("in_rdreq", 64'(in_rdreq), 64'(pop));
        check("underflow", 64'(underflow), 64'(m_uf));
`ifdef RLE_UNDERFLOW_CNT_EN
        check("underflow_cnt", 64'(underflow_cnt), 64'(m_ucnt));
`endif
        if (in_rdreq) pops_seen++;
        if (out_valid && rd && (out_data == watch_pat)) watch_cnt++;
        @(posedge CLK);
        if (fl) begin
            model_reset();
        end else if (m_idle) begin
            if (pop) begin
                model_load();
                m_idle = 1'b0;
            end
        end else if (m_words.size() != 0) begin
            if (rd) begin
                m_last = m_words.pop_front();
                if (m_words.size() == 0) begin
                    if (pop) model_load();
                    else     model_underflow();
                end
            end
        end else begin
            if (rd) model_underflow();
            if (pop) model_load();
        end
        @(negedge CLK);
    endtask

    // Asserts RST between clock edges while the FIFO holds an entry.
    task automatic async_reset();
        out_rdreq = 1'b1;
        flush     = 1'b0;
        in_empty  = (fifo.size() == 0);
        in_data   = (fifo.size() != 0) ? fifo[0] : '0;
        #3;
        RST = 1'b1;
        #1;
        check("rst_async_out_valid", 64'(out_valid), 64'd0);
        check("rst_async_out_data", 64'(out_data), 64'd0);
        check("rst_async_in_rdreq", 64'(in_rdreq), 64'd0);
        model_reset();
        @(posedge CLK);
        #1;
        check("rst_hold_in_rdreq", 64'(in_rdreq), 64'd0);
        check("rst_hold_underflow", 64'(underflow), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST       = 1'b1;
        in_data   = '0;
        in_empty  = 1'b1;
        out_rdreq = 1'b0;
        flush     = 1'b0;
        watch_pat = 32'hFFFF_FFFF;
        watch_cnt = 0;
        pops_seen = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_in_rdreq", 64'(in_rdreq), 64'd0);
        check("reset_underflow", 64'(underflow), 64'd0);
        RST = 1'b0;
        cycle(1'b0, 1'b0);

        // Two back-to-back entries with the player always ready, then run dry.
        push(2, 32'h0000_00A5);
        push(0, 32'h0000_005A);
        pops_seen = 0;
        repeat (8) cycle(1'b1, 1'b0);
        check("ab_pop_count", 64'(pops_seen), 64'd2);

        // D_END pattern consumed on alternating strobes.
        cycle(1'b0, 1'b1);
        push(3, 32'h8000_0001);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(logic'(i % 2 == 0), 1'b0);

        // Maximum repeat count must produce exactly 2^CW words.
        cycle(1'b0, 1'b1);
        watch_pat = 32'h0DEA_0001;
        watch_cnt = 0;
        push(65535, watch_pat);
        push(0, 32'h0BEE_F002);
        for (int i = 0; i < 65540; i++) cycle(1'b1, 1'b0);
        check("max_cnt_words", 64'(watch_cnt), 64'd65536);
        watch_pat = 32'hFFFF_FFFF;

        // Underflow recovery.
        cycle(1'b0, 1'b1);
        push(0, 32'h0000_0011);
        cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0);
        push(1, 32'h0000_0022);
        repeat (4) cycle(1'b1, 1'b0);

        // Flush mid-run with a pending entry.
        cycle(1'b0, 1'b1);
        push(7, 32'h0000_0033);
        cycle(1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b0);
        push(0, 32'h0000_0044);
        cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);

        // Asynchronous reset mid-run, then re-prime from the pending entry.
        cycle(1'b0, 1'b1);
        push(9, 32'h0000_0055);
        push(2, 32'h0000_0066);
        repeat (3) cycle(1'b1, 1'b0);
        async_reset();
        repeat (5) cycle(1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (($urandom_range(0, 3) == 0) && (fifo.size() < 8))
                push(int'($urandom_range(0, 4)), $urandom);
            cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
